// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream valid/ready/data,
// downstream valid/ready/data, a squash strobe and the occupancy count.
interface pipe_stage_chain_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             flush;
   logic [CW-1:0]    count;

   // Producer/consumer side: offers input, accepts output, may squash.
   modport master (
      output in_valid, in_data, out_ready, flush,
      input  in_ready, out_valid, out_data, count
   );

   // The chain itself.
   modport slave (
      input  in_valid, in_data, out_ready, flush,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain: DEPTH valid/ready stages carrying WIDTH-bit
// words, with bubble collapse, synchronous flush and a registered occupancy
// count. Stage 0 faces the producer, stage DEPTH-1 drives out_data.
module pipe_stage_chain #(
   parameter int unsigned      WIDTH      = 32,
   parameter int unsigned      DEPTH      = 2,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_chain_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d     [DEPTH];
   logic [DEPTH:0]   r;
   logic [DEPTH-1:0] inc_v;
   logic [WIDTH-1:0] inc_d [DEPTH];
   logic [CW-1:0]    count_q;
   logic             in_fire;
   logic             out_fire;

   // Ready ripples back from the consumer; an empty stage is always ready,
   // which is what lets bubbles collapse while the output is stalled.
   always_comb begin
      // NOTE: default assigned first so no path leaves r unassigned (no latch).
      r        = '0;
      r[DEPTH] = bus.out_ready;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         r[k] = ~v[k] | r[k+1];
      end
   end

   // Handshake outputs are masked by flush and reset; out_data is raw.
   assign bus.in_ready  = r[0] & ~bus.flush & ~rst;
   assign bus.out_valid = v[DEPTH-1] & ~bus.flush & ~rst;
   assign bus.out_data  = d[DEPTH-1];
   assign bus.count     = count_q;

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   // What each stage would load: the producer for stage 0, the upstream stage otherwise.
   always_comb begin
      inc_v[0] = in_fire;
      inc_d[0] = bus.in_data;
      for (int k = 1; k < int'(DEPTH); k++) begin
         inc_v[k] = v[k-1];
         inc_d[k] = d[k-1];
      end
   end

   // Stage registers and occupancy count; reset beats flush beats transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         v       <= '0;
         count_q <= '0;
         // NOTE: data registers are reset too, since out_data is visible even when invalid.
         for (int k = 0; k < int'(DEPTH); k++) begin
            d[k] <= RESET_DATA;
         end
      end else if (bus.flush) begin
         v       <= '0;
         count_q <= '0;
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (r[k]) begin
               // NOTE: non-blocking, so each stage loads its neighbour's pre-edge value.
               v[k] <= inc_v[k];
               if (inc_v[k]) begin
                  d[k] <= inc_d[k];
               end
            end
         end
         count_q <= count_q + CW'(in_fire) - CW'(out_fire);
      end
   end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain (WIDTH=32, DEPTH=2). Accepted words
// go into a scoreboard queue and are compared as they leave the chain.
module tb_pipe_stage_chain;
   localparam int unsigned      WIDTH = 32;
   localparam int unsigned      DEPTH = 2;
   localparam logic [WIDTH-1:0] RDATA = 32'hDEAD_BEEF;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   logic [WIDTH-1:0] sb[$];

   pipe_stage_chain_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   pipe_stage_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(RDATA)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check handshake outputs before the edge,
   // update the scoreboard, then advance to the next negedge.
   task automatic step(input logic iv, input logic [31:0] idata, input logic ordy,
                       input logic fl, input logic exp_ird, input logic exp_ov);
      bus.in_valid  = iv;
      bus.in_data   = idata;
      bus.out_ready = ordy;
      bus.flush     = fl;
      #2;
      check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ird});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (fl || rst) sb.delete();
      if (iv && exp_ird) sb.push_back(idata);
      if (bus.out_valid && ordy) begin
         if (sb.size() == 0) check("unexpected_out", bus.out_data, 32'hFFFF_FFFF);
         else                check("out_data", bus.out_data, sb.pop_front());
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_count(input int exp);
      check("count", {30'd0, bus.count}, exp);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      bus.flush     = 1'b0;
      #2;
      check("rst_in_ready", {31'd0, bus.in_ready}, 0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset_out_data", bus.out_data, RDATA);
      check_count(0);

      // 1: single word, latency and count sequence
      step(1, 20, 1, 0, 1, 0); check_count(1);
      step(0, 0, 1, 0, 1, 0);  check_count(1);
      step(0, 0, 1, 0, 1, 1);  check_count(0);
      step(0, 0, 1, 0, 1, 0);  check_count(0);

      // 2: back-to-back stream 1..8, then drain
      for (int i = 1; i <= 8; i++) begin
         step(1, i, 1, 0, 1, (i >= 3));
         check_count((i < 2) ? i : 2);
      end
      step(0, 0, 1, 0, 1, 1); check_count(1);
      step(0, 0, 1, 0, 1, 1); check_count(0);

      // 3: fill while stalled, back-pressure, then drain without gaps
      step(1, 10, 0, 0, 1, 0); check_count(1);
      step(1, 11, 0, 0, 1, 0); check_count(2);
      check("stall_data", bus.out_data, 10);
      step(1, 12, 0, 0, 0, 1); check_count(2);
      check("stall_hold", bus.out_data, 10);
      step(1, 12, 0, 0, 0, 1); check_count(2);
      step(1, 12, 1, 0, 1, 1); check_count(2);
      step(0, 0, 1, 0, 1, 1);  check_count(1);
      step(0, 0, 1, 0, 1, 1);  check_count(0);

      // 4: bubble collapse behind a stalled output
      step(1, 5, 0, 0, 1, 0);  check_count(1);
      step(0, 0, 0, 0, 1, 0);  check_count(1);
      check("bubble_head", bus.out_data, 5);
      step(1, 6, 0, 0, 1, 1);  check_count(2);
      step(0, 0, 1, 0, 1, 1);  check_count(1);
      step(0, 0, 1, 0, 1, 1);  check_count(0);

      // 5: flush a full chain while a word is offered
      step(1, 40, 1, 0, 1, 0); check_count(1);
      step(1, 41, 1, 0, 1, 0); check_count(2);
      step(1, 42, 1, 1, 0, 0); check_count(0);
      check("flush_data_hold", bus.out_data, 40);
      step(0, 0, 1, 0, 1, 0);  check_count(0);
      step(1, 30, 1, 0, 1, 0); check_count(1);
      step(0, 0, 1, 0, 1, 0);  check_count(1);
      step(0, 0, 1, 0, 1, 1);  check_count(0);

      // 6: reset mid-stream, then resume
      step(1, 50, 1, 0, 1, 0); check_count(1);
      step(1, 51, 1, 0, 1, 0); check_count(2);
      rst = 1'b1;
      step(1, 52, 1, 0, 0, 0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("post_rst_out_valid", {31'd0, bus.out_valid}, 0);
      check("post_rst_out_data", bus.out_data, RDATA);
      check_count(0);
      step(1, 60, 1, 0, 1, 0); check_count(1);
      step(1, 61, 1, 0, 1, 0); check_count(2);
      step(0, 0, 1, 0, 1, 1);  check_count(1);
      step(0, 0, 1, 0, 1, 1);  check_count(0);

      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline register chain. It succeeds the plain always-loading inter-stage register. It carries WIDTH-bit data through DEPTH register stages with a valid/ready handshake per stage, stall absorption (bubble collapse), synchronous flush and an occupancy count. It sits between processor pipeline stages (fetch→decode→execute) wherever a stage must stall or be squashed.

Parameters:
WIDTH, 32, data width in bits (≥1)
DEPTH, 2, number of register stages (≥1)
RESET_DATA, 0, value loaded into every stage data register on reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream offers in_data
in_ready  output  1  chain accepts in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds valid data
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  last stage data register
flush  input  1  squash all stages
count  output  clog2(DEPTH+1)  number of valid stages, registered

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output side). Each stage has a valid bit v[k] and a data register d[k].
- Reset (rst=1 at posedge): all v[k]=0, all d[k]=RESET_DATA, count=0. Reset dominates flush and all handshakes.
- While rst=1: in_ready=0 and out_valid=0 (combinationally masked).
- Ready chain (combinational):
  - r[DEPTH] = out_ready
  - r[k] = ~v[k] | r[k+1]
  - in_ready = r[0] & ~flush & ~rst
- out_valid = v[DEPTH-1] & ~flush & ~rst.
- out_data = d[DEPTH-1], always driven, including when invalid.
- Transfer into stage k happens when r[k]=1 at posedge:
  - v[k] <= incoming valid (in_valid & in_ready for k=0; v[k-1] for k>0).
  - d[k] <= incoming data only if the incoming valid is 1; otherwise d[k] holds.
- When r[k]=0, the stage holds both v[k] and d[k].
- Ordering and integrity: data exits in acceptance order. No duplication, no loss except by flush or rst.
- Stall stability: while out_valid=1 and out_ready=0, out_valid and out_data stay constant.
- Latency and throughput: with out_ready held 1, a word accepted at edge N appears on out_data after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid. Throughput is 1 word/cycle.
- Bubble collapse: an empty stage accepts from upstream even when downstream is stalled. A stalled chain with any empty stage still reports in_ready=1.
- Full chain (count=DEPTH):
  - out_ready=0 → in_ready=0.
  - out_ready=1 → in_ready=1. Accept and emit happen on the same edge and count is unchanged.
- Flush (flush=1 at posedge, rst=0):
  - All v[k] <= 0 and count <= 0. d[k] hold.
  - No input accepted and no output transfer in the flush cycle (both masked).
  - The first post-flush input is accepted the cycle after flush deasserts.
- count: registered, next = count + in_fire − out_fire, where in_fire = in_valid&in_ready and out_fire = out_valid&out_ready. It must always equal the popcount of v.
- The combinational path out_ready → in_ready is intentional; the spec does not require it to be registered.

Test Plan:
1. DEPTH=2, WIDTH=32. rst 1 cycle, then in_data=20, in_valid=1 for 1 cycle, out_ready=1 → out_valid=1, out_data=20 two edges after acceptance, then out_valid=0; count sequence 0,1,1,0.
2. Stream 1..8 back-to-back with out_ready=1 → outputs 1..8 on consecutive cycles starting at cycle 2; in_ready constantly 1; count steady at 2.
3. out_ready=0, offer 10,11,12 → 10 and 11 accepted, in_ready=0 while 12 is offered, count=2, out_data held at 10. Raise out_ready → 10,11,12 emitted in order with no gaps.
4. Bubble collapse: stage1 holds 5, stage0 empty, out_ready=0, offer 6 → in_ready=1, 6 accepted, count=2. Raise out_ready → outputs 5 then 6.
5. Flush with count=2 (holding 40,41), in_valid=1 with 42 → 42 not accepted. Next cycle out_valid=0, count=0. Offer 30 afterwards → out_data=30 after 2 cycles.
6. Assert rst mid-stream (count=2, in_valid=1) → in_ready=0 during rst. After the edge: out_valid=0, out_data=RESET_DATA, count=0. Streaming resumes correctly after rst drops.
